// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART FIFO: trigger-level encodings, error-tag bit
// positions and the trigger threshold helper.
package uart_fifo_pkg;

   localparam logic [1:0] TRIG_1  = 2'd0;
   localparam logic [1:0] TRIG_Q  = 2'd1;
   localparam logic [1:0] TRIG_H  = 2'd2;
   localparam logic [1:0] TRIG_NF = 2'd3;

   localparam int ERR_W_DEF = 3;
   localparam int ERR_PAR   = 0;
   localparam int ERR_FRM   = 1;
   localparam int ERR_BRK   = 2;

   function automatic int trig_level(input logic [1:0] sel, input int depth);
      case (sel)
         TRIG_1:  return 1;
         TRIG_Q:  return depth / 4;
         TRIG_H:  return depth / 2;
         default: return depth - 2;
      endcase
   endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the UART FIFO: synchronous write port, asynchronous read
// port so the head entry falls straight through to the output.
module uart_fifo_ram #(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_ext.sv
// FWFT synchronous FIFO for the UART datapath with trigger level, sticky
// overrun and optional per-entry error tags (enabled by UART_FIFO_ERR_TAG_EN).
module uart_fifo_ext
   import uart_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int ERR_W = ERR_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [ERR_W-1:0]         wr_err,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [ERR_W-1:0]         rd_err,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [1:0]               trig_sel,
   output logic                     trig_hit,
   output logic                     overrun,
   input  logic                     overrun_clr,
   output logic                     err_in_fifo
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef UART_FIFO_ERR_TAG_EN
   localparam int RW = WIDTH + ERR_W;
`else
   localparam int RW = WIDTH;
`endif

   logic [CW-1:0] wptr;
   logic [CW-1:0] rptr;
   logic          push_ok;
   logic          pop_ok;
   logic [RW-1:0] ram_wdata;
   logic [RW-1:0] ram_rdata;

   assign count   = wptr - rptr;
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign pop_ok  = rd_en && !empty;
   assign push_ok = wr_en && (!full || pop_ok);

   assign trig_hit = (count >= CW'(trig_level(trig_sel, DEPTH)));

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok)
            wptr <= wptr + 1'b1;
         if (pop_ok)
            rptr <= rptr + 1'b1;
      end
   end

   // Drop-while-full sets the flag ahead of a same-cycle clear; flush writes never count.
   always_ff @(posedge clk) begin
      if (rst)
         overrun <= 1'b0;
      else if (wr_en && full && !rd_en && !flush)
         overrun <= 1'b1;
      else if (overrun_clr)
         overrun <= 1'b0;
   end

`ifdef UART_FIFO_ERR_TAG_EN
   logic [CW-1:0]    errcnt;
   logic [ERR_W-1:0] head_err;
   logic             err_push;
   logic             err_pop;

   assign ram_wdata = {wr_err, wr_data};
   assign head_err  = ram_rdata[RW-1:WIDTH];
   assign err_push  = push_ok && (|wr_err);
   assign err_pop   = pop_ok && (|head_err);

   always_ff @(posedge clk) begin
      if (rst || flush)
         errcnt <= '0;
      else if (err_push && !err_pop)
         errcnt <= errcnt + 1'b1;
      else if (err_pop && !err_push)
         errcnt <= errcnt - 1'b1;
   end

   assign rd_err      = empty ? '0 : head_err;
   assign err_in_fifo = (errcnt != '0);
`else
   logic unused_wr_err;

   assign unused_wr_err = ^wr_err;
   assign ram_wdata     = wr_data;
   assign rd_err        = '0;
   assign err_in_fifo   = 1'b0;
`endif

   assign rd_data = empty ? '0 : ram_rdata[WIDTH-1:0];

   uart_fifo_ram #(
      .DEPTH (DEPTH),
      .DW    (RW)
   ) u_ram (
      .clk   (clk),
      .we    (push_ok && !rst && !flush),
      .waddr (wptr[AW-1:0]),
      .wdata (ram_wdata),
      .raddr (rptr[AW-1:0]),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_uart_fifo_ext.sv
// Directed self-checking bench for uart_fifo_ext at DEPTH=16; error-tag
// expectations follow UART_FIFO_ERR_TAG_EN.
module tb_uart_fifo_ext;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [2:0] wr_err;
   logic       rd_en;
   logic [7:0] rd_data;
   logic [2:0] rd_err;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic [1:0] trig_sel;
   logic       trig_hit;
   logic       overrun;
   logic       overrun_clr;
   logic       err_in_fifo;

   int vectors = 0;
   int miscompares = 0;

`ifdef UART_FIFO_ERR_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   uart_fifo_ext #(.DEPTH(16), .WIDTH(8), .ERR_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .wr_err      (wr_err),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_err      (rd_err),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .trig_sel    (trig_sel),
      .trig_hit    (trig_hit),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .err_in_fifo (err_in_fifo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0; rst = 1'b0;
      wr_err = 3'b000;
   endtask

   task automatic push(input logic [7:0] d, input logic [2:0] e);
      wr_en = 1'b1; wr_data = d; wr_err = e;
      tick();
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      vectors++;
      if (rd_data !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s rd_data=%h expected=%h", name, rd_data, exp);
      end
      rd_en = 1'b1;
      tick();
   endtask

   task automatic check_count(input string name, input logic [4:0] exp);
      vectors++;
      if (count !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s count=%0d expected=%0d", name, count, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s got=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      trig_sel = 2'd0;
      do_reset();
      check_count("reset count", 5'd0);
      check_bit("reset empty", empty, 1'b1);
      check_bit("reset full", full, 1'b0);
      check_bit("reset trig_hit", trig_hit, 1'b0);
      check_bit("reset overrun", overrun, 1'b0);
      check_bit("reset err_in_fifo", err_in_fifo, 1'b0);
      vectors++;
      if (rd_data !== 8'h00 || rd_err !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset head data=%h err=%b expected=00/000", rd_data, rd_err);
      end
   endtask

   task automatic test_trig_levels();
      do_reset();
      push(8'h01, 3'b000);
      trig_sel = 2'd0; #1 check_bit("trig sel0 at 1", trig_hit, 1'b1);
      trig_sel = 2'd1; #1 check_bit("trig sel1 at 1", trig_hit, 1'b0);
      push(8'h02, 3'b000); push(8'h03, 3'b000);
      #1 check_bit("trig sel1 at 3", trig_hit, 1'b0);
      push(8'h04, 3'b000);
      #1 check_bit("trig sel1 at 4", trig_hit, 1'b1);
      trig_sel = 2'd2; #1 check_bit("trig sel2 at 4", trig_hit, 1'b0);
      push(8'h05, 3'b000); push(8'h06, 3'b000); push(8'h07, 3'b000);
      #1 check_bit("trig sel2 at 7", trig_hit, 1'b0);
      push(8'h08, 3'b000);
      #1 check_bit("trig sel2 at 8", trig_hit, 1'b1);
      do_reset();
   endtask

   task automatic test_fill_trigger();
      trig_sel = 2'd3;
      for (int i = 1; i <= 15; i++) begin
         push(8'(8'h10 + i), 3'b000);
         check_count("fill count", 5'(i));
         check_bit("fill trig_hit", trig_hit, (i >= 14));
      end
      check_bit("fill full at 15", full, 1'b0);
      vectors++;
      if (rd_data !== 8'h11) begin
         miscompares++;
         $display("[TB] FAIL fwft head rd_data=%h expected=11", rd_data);
      end
   endtask

   task automatic test_overrun();
      push(8'h20, 3'b000);
      check_bit("full at 16", full, 1'b1);
      push(8'hAA, 3'b000);
      check_bit("overrun set", overrun, 1'b1);
      check_count("overrun count", 5'd16);
      for (int i = 0; i < 16; i++)
         pop_expect("overrun drain", 8'(8'h11 + i));
      check_bit("drained empty", empty, 1'b1);
      check_bit("overrun sticky", overrun, 1'b1);
      overrun_clr = 1'b1;
      tick();
      check_bit("overrun cleared", overrun, 1'b0);
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++)
         push(8'(8'h60 + i), 3'b000);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
      tick();
      check_count("full rw count", 5'd16);
      check_bit("full rw overrun", overrun, 1'b0);
      for (int i = 1; i < 16; i++)
         pop_expect("full rw drain", 8'(8'h60 + i));
      pop_expect("full rw last", 8'h55);
      check_bit("full rw empty", empty, 1'b1);
   endtask

   task automatic test_err_tag();
      push(8'h41, 3'b001);
      push(8'h42, 3'b000);
      check_bit("err_in_fifo set", err_in_fifo, TAG_EN);
      vectors++;
      if (rd_err !== (TAG_EN ? 3'b001 : 3'b000)) begin
         miscompares++;
         $display("[TB] FAIL head rd_err=%b expected=%b", rd_err, TAG_EN ? 3'b001 : 3'b000);
      end
      pop_expect("err head", 8'h41);
      check_bit("err_in_fifo cleared", err_in_fifo, 1'b0);
      pop_expect("err second", 8'h42);
      // Tagged push and tagged pop in one cycle leave the count unchanged.
      push(8'h43, 3'b100);
      wr_en = 1'b1; wr_data = 8'h44; wr_err = 3'b010; rd_en = 1'b1;
      tick();
      check_bit("err net change", err_in_fifo, TAG_EN);
      pop_expect("err net head", 8'h44);
      check_bit("err net drained", err_in_fifo, 1'b0);
   endtask

   task automatic test_empty_rw();
      logic [7:0] q[$];
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
      tick();
      check_count("empty rw count", 5'd1);
      pop_expect("empty rw head", 8'h77);
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h80 + i);
         if (i % 2 == 1) begin
            vectors++;
            if (rd_data !== q[0]) begin
               miscompares++;
               $display("[TB] FAIL wrap interleave rd_data=%h expected=%h", rd_data, q[0]);
            end
            rd_en = 1'b1;
            void'(q.pop_front());
         end
         q.push_back(8'(8'h80 + i));
         tick();
      end
      check_count("wrap count", 5'd10);
      while (q.size() > 0)
         pop_expect("wrap drain", q.pop_front());
   endtask

   task automatic test_flush();
      for (int i = 0; i < 16; i++)
         push(8'(8'hC0 + i), (i == 14) ? 3'b010 : 3'b000);
      push(8'hEE, 3'b000);
      for (int i = 0; i < 11; i++)
         pop_expect("pre-flush drain", 8'(8'hC0 + i));
      check_count("pre-flush count", 5'd5);
      check_bit("pre-flush overrun", overrun, 1'b1);
      check_bit("pre-flush err_in_fifo", err_in_fifo, TAG_EN);
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
      tick();
      check_bit("flush empty", empty, 1'b1);
      check_count("flush count", 5'd0);
      check_bit("flush keeps overrun", overrun, 1'b1);
      check_bit("flush err_in_fifo", err_in_fifo, 1'b0);
      vectors++;
      if (rd_data !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL flush rd_data=%h expected=00", rd_data);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0; wr_err = '0;
      rd_en = 1'b0; trig_sel = 2'd0; overrun_clr = 1'b0;
      test_reset();
      test_trig_levels();
      test_fill_trigger();
      test_overrun();
      test_full_rw();
      test_err_tag();
      test_empty_rw();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
